rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
  HOLD_CYCLES  16    cycles all resets stay asserted in HOLD (>=1)
  INIT_TIMEOUT 1024  maximum cycles spent waiting for memory init (>=1)
  GAP_CYCLES   4     cycles between peripheral release and core release (>=1)
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
  clk              in   1  single clock, rising edge
  rst_i            in   1  asynchronous, active-high reset
  sw_rst_req_i     in   1  software reset request, sampled in RUN
  wdt_rst_req_i    in   1  watchdog reset request, sampled in RUN
  mem_init_done_i  in   1  memory initialisation complete, level
  mem_rst_o        out  1  instruction/data memory reset, active-high
  periph_rst_o     out  1  peripheral reset, active-high
  core_rst_o       out  1  pipeline core reset, active-high
  ready_o          out  1  high only in RUN
  rst_cause_o      out  2  00 power-on, 01 software, 10 watchdog
  init_timeout_o   out  1  sticky; memory init timed out in the current sequence
REQ-003 The block SHALL use one clock, clk; rst_i SHALL be asynchronous and active-high.
REQ-004 All outputs SHALL be driven directly from flops.

Function
REQ-005 The FSM SHALL have four states: HOLD, INIT, PERIPH and RUN.
REQ-006 One internal down-counter SHALL serve all states, sized clog2(max(HOLD_CYCLES, INIT_TIMEOUT, GAP_CYCLES)) + 1 bits; it SHALL be reloaded on every state entry.
REQ-007 HOLD: mem, periph and core resets = 1; ready_o = 0; the state SHALL last exactly HOLD_CYCLES cycles, then go to INIT.
REQ-008 INIT: mem_rst_o = 0, the other resets = 1; mem_init_done_i = 1 sampled at a clock edge SHALL move to PERIPH on that edge.
REQ-009 INIT: after INIT_TIMEOUT cycles without done, the FSM SHALL go to PERIPH and set init_timeout_o = 1.
REQ-010 If done and timeout occur on the same edge, done SHALL win and init_timeout_o SHALL stay 0.
REQ-011 PERIPH: mem_rst_o = 0, periph_rst_o = 0, core_rst_o = 1; the state SHALL last exactly GAP_CYCLES cycles, then go to RUN.
REQ-012 RUN: all resets = 0 and ready_o = 1.
REQ-013 RUN: sw_rst_req_i or wdt_rst_req_i high at an edge SHALL move to HOLD, with all resets asserted on that same edge.
REQ-014 A request accepted in RUN SHALL set rst_cause_o; if both requests are high together, watchdog SHALL win (10).
REQ-015 Requests SHALL be ignored in HOLD, INIT and PERIPH, with no queuing and no restart of the sequence.
REQ-016 init_timeout_o SHALL clear on every entry to HOLD; rst_cause_o SHALL hold its value until the next accepted request or rst_i.
REQ-017 Release order SHALL always be mem, then periph, then core; core_rst_o SHALL never be 0 while periph_rst_o or mem_rst_o is 1.
REQ-018 Latency: with done already high, core_rst_o SHALL fall HOLD_CYCLES + 1 + GAP_CYCLES edges after the first edge in HOLD (21 with defaults).

Reset
REQ-019 rst_i high SHALL immediately, without a clock, force state HOLD, all reset outputs = 1, ready_o = 0, rst_cause_o = 00, init_timeout_o = 0 and the counter reloaded to HOLD_CYCLES.
REQ-020 rst_i asserted mid-sequence or in RUN SHALL abort the sequence, and the outputs SHALL follow REQ-019.
REQ-021 On rst_i deassertion the sequence SHALL restart from the full HOLD period.

Verification
REQ-022 Power-on, defaults, done tied 1: mem_rst_o falls at edge 16, periph_rst_o at edge 17, core_rst_o and ready_o at edge 21; rst_cause_o = 00.
REQ-023 Done tied 0, INIT_TIMEOUT = 8: periph_rst_o falls 8 cycles after mem_rst_o; init_timeout_o = 1 until the next request; core released 4 cycles later.
REQ-024 In RUN, sw and wdt requests pulsed in the same cycle: all resets = 1 on the next edge, rst_cause_o = 10, full sequence replays, init_timeout_o cleared.
REQ-025 sw_rst_req_i pulsed during INIT and again during PERIPH: no effect on timing; rst_cause_o unchanged.
REQ-026 rst_i asserted between clock edges during PERIPH: resets rise asynchronously, cause = 00; after release the full 21-cycle sequence repeats.
REQ-027 Across all tests, an assertion SHALL check the release-order invariant of REQ-017 and that ready_o equals (state == RUN).

Source files
------------

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: request inputs and reset/status outputs of the reset sequencer
interface rst_seq_ctrl_if;
    logic       sw_rst_req_i;
    logic       wdt_rst_req_i;
    logic       mem_init_done_i;
    logic       mem_rst_o;
    logic       periph_rst_o;
    logic       core_rst_o;
    logic       ready_o;
    logic [1:0] rst_cause_o;
    logic       init_timeout_o;
    modport master (
        output sw_rst_req_i, wdt_rst_req_i, mem_init_done_i,
        input  mem_rst_o, periph_rst_o, core_rst_o, ready_o, rst_cause_o, init_timeout_o
    );
    modport slave (
        input  sw_rst_req_i, wdt_rst_req_i, mem_init_done_i,
        output mem_rst_o, periph_rst_o, core_rst_o, ready_o, rst_cause_o, init_timeout_o
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset release (mem, then periph, then core) with software/watchdog re-entry
module rst_seq_ctrl #(
    parameter int HOLD_CYCLES  = 16,
    parameter int INIT_TIMEOUT = 1024,
    parameter int GAP_CYCLES   = 4
) (
    input logic           clk,
    input logic           rst_i,
    rst_seq_ctrl_if.slave bus
);
    localparam int MAX_HI  = (HOLD_CYCLES > INIT_TIMEOUT) ? HOLD_CYCLES : INIT_TIMEOUT;
    localparam int MAX_ALL = (MAX_HI > GAP_CYCLES) ? MAX_HI : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    typedef enum logic [1:0] {HOLD, INIT, PERIPH, RUN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_mem_rst;
    logic            r_periph_rst;
    logic            r_core_rst;
    logic            r_ready;
    logic [1:0]      r_cause;
    logic            r_timeout;
    logic            w_last;
    logic            w_req;

    assign w_last = r_cnt == CW'(1);
    assign w_req  = bus.sw_rst_req_i | bus.wdt_rst_req_i;

    assign bus.mem_rst_o      = r_mem_rst;
    assign bus.periph_rst_o   = r_periph_rst;
    assign bus.core_rst_o     = r_core_rst;
    assign bus.ready_o        = r_ready;
    assign bus.rst_cause_o    = r_cause;
    assign bus.init_timeout_o = r_timeout;

    // Sequencer: the shared down-counter is reloaded on every state entry; a state ends when it reads 1
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= HOLD;
            r_cnt        <= CW'(HOLD_CYCLES);
            r_mem_rst    <= 1'b1;
            r_periph_rst <= 1'b1;
            r_core_rst   <= 1'b1;
            r_ready      <= 1'b0;
            r_cause      <= 2'b00;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_last) begin
                        r_state   <= INIT;
                        r_cnt     <= CW'(INIT_TIMEOUT);
                        r_mem_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                INIT: begin
                    if (bus.mem_init_done_i || w_last) begin
                        r_state      <= PERIPH;
                        r_cnt        <= CW'(GAP_CYCLES);
                        r_periph_rst <= 1'b0;
                        r_timeout    <= ~bus.mem_init_done_i;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                PERIPH: begin
                    if (w_last) begin
                        r_state    <= RUN;
                        r_cnt      <= CW'(HOLD_CYCLES);
                        r_core_rst <= 1'b0;
                        r_ready    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RUN: begin
                    if (w_req) begin
                        r_state      <= HOLD;
                        r_cnt        <= CW'(HOLD_CYCLES);
                        r_mem_rst    <= 1'b1;
                        r_periph_rst <= 1'b1;
                        r_core_rst   <= 1'b1;
                        r_ready      <= 1'b0;
                        r_cause      <= bus.wdt_rst_req_i ? 2'b10 : 2'b01;
                        r_timeout    <= 1'b0;
                    end
                end
                default: r_state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: scoreboard bench; stimulus queues expected output changes, monitor matches them
module tb_rst_seq_ctrl;
    typedef struct {
        int         cyc;
        logic [6:0] o;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;
    int   cyc   = 0;
    int   base  = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    rst_seq_ctrl_if bus();

    rst_seq_ctrl #(.HOLD_CYCLES(16), .INIT_TIMEOUT(8), .GAP_CYCLES(4)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge counter used to timestamp every observed output change
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] outs();
        return {bus.mem_rst_o, bus.periph_rst_o, bus.core_rst_o, bus.ready_o,
                bus.rst_cause_o, bus.init_timeout_o};
    endfunction

    task automatic push(input int rel, input logic m, input logic p, input logic c,
                        input logic r, input logic [1:0] cause, input logic t);
        exp_t e;
        e.cyc = (rel < 0) ? -1 : base + rel;
        e.o   = {m, p, c, r, cause, t};
        q.push_back(e);
    endtask

    task automatic pulse(input logic s, input logic w);
        bus.sw_rst_req_i  = s;
        bus.wdt_rst_req_i = w;
        @(negedge clk);
        bus.sw_rst_req_i  = 1'b0;
        bus.wdt_rst_req_i = 1'b0;
    endtask

    // Monitor: every change of the output vector must match the head of the expectation queue
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        exp_t       e;
        prev = 'x;
        forever begin
            @(negedge clk or posedge rst_i);
            #1;
            cur = outs();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got outs=%b at cyc=%0d, expected no change", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.o || (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL out_event: got outs=%b cyc=%0d, expected outs=%b cyc=%0d",
                                 cur, cyc, e.o, e.cyc);
                    end
                end
            end
            prev = cur;
        end
    end

    // Release-order invariant and ready/state agreement, checked every cycle
    always @(negedge clk) begin
        checks++;
        assert (!(!bus.core_rst_o && (bus.periph_rst_o || bus.mem_rst_o)) &&
                !(!bus.periph_rst_o && bus.mem_rst_o) &&
                (bus.ready_o == (2'(dut.r_state) == 2'd3)))
        else begin
            errors++;
            $display("FAIL invariant: got mem=%b periph=%b core=%b ready=%b state=%0d at cyc=%0d, expected ordered release and ready==RUN",
                     bus.mem_rst_o, bus.periph_rst_o, bus.core_rst_o, bus.ready_o, dut.r_state, cyc);
        end
    end

    initial begin
        bus.sw_rst_req_i    = 1'b0;
        bus.wdt_rst_req_i   = 1'b0;
        bus.mem_init_done_i = 1'b1;
        push(-1, 1, 1, 1, 0, 2'b00, 0);
        repeat (3) @(negedge clk);
        // Power-on with done high
        rst_i = 1'b0;
        base  = cyc;
        push(16, 0, 1, 1, 0, 2'b00, 0);
        push(17, 0, 0, 1, 0, 2'b00, 0);
        push(21, 0, 0, 0, 1, 2'b00, 0);
        repeat (24) @(negedge clk);
        // Software request, done low: init timeout, with ignored requests in INIT and PERIPH
        bus.mem_init_done_i = 1'b0;
        base = cyc;
        push(1,  1, 1, 1, 0, 2'b01, 0);
        push(17, 0, 1, 1, 0, 2'b01, 0);
        push(25, 0, 0, 1, 0, 2'b01, 1);
        push(29, 0, 0, 0, 1, 2'b01, 1);
        pulse(1, 0);
        repeat (19) @(negedge clk);
        pulse(1, 0);
        repeat (5) @(negedge clk);
        pulse(1, 0);
        repeat (5) @(negedge clk);
        // Simultaneous sw and wdt: watchdog wins, timeout flag cleared
        bus.mem_init_done_i = 1'b1;
        base = cyc;
        push(1,  1, 1, 1, 0, 2'b10, 0);
        push(17, 0, 1, 1, 0, 2'b10, 0);
        push(18, 0, 0, 1, 0, 2'b10, 0);
        push(22, 0, 0, 0, 1, 2'b10, 0);
        pulse(1, 1);
        repeat (24) @(negedge clk);
        // Done arrives on the very edge the init timeout expires: done wins
        bus.mem_init_done_i = 1'b0;
        base = cyc;
        push(1,  1, 1, 1, 0, 2'b10, 0);
        push(17, 0, 1, 1, 0, 2'b10, 0);
        push(25, 0, 0, 1, 0, 2'b10, 0);
        push(29, 0, 0, 0, 1, 2'b10, 0);
        pulse(0, 1);
        repeat (23) @(negedge clk);
        bus.mem_init_done_i = 1'b1;
        repeat (8) @(negedge clk);
        // rst_i asserted between edges during PERIPH, then full replay
        base = cyc;
        push(1,  1, 1, 1, 0, 2'b01, 0);
        push(17, 0, 1, 1, 0, 2'b01, 0);
        push(18, 0, 0, 1, 0, 2'b01, 0);
        push(19, 1, 1, 1, 0, 2'b00, 0);
        pulse(1, 0);
        repeat (18) @(posedge clk);
        #2;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        base  = cyc;
        push(16, 0, 1, 1, 0, 2'b00, 0);
        push(17, 0, 0, 1, 0, 2'b00, 0);
        push(21, 0, 0, 0, 1, 2'b00, 0);
        repeat (25) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d unmatched expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
